// File: rtl/dcache_pkg.sv
// Shared definitions for the two-way data cache: FSM encodings, derived widths, word select.
package dcache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_MISS   = 3'd1;
    localparam state_t S_WB     = 3'd2;
    localparam state_t S_REFILL = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // Widest line the word-select helper accepts.
    localparam int LINE_MAX_W = 1024;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - idx_w(sets) - off_w(line_w);
    endfunction

    function automatic logic [31:0] word_sel(input logic [LINE_MAX_W-1:0] line,
                                             input logic [4:0] wsel);
        return line[{wsel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid/dirty/tag/line flops, combinational read, one write port.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int SETS   = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256,
    parameter int WSEL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              we_line_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic              we_word_i,
    input  logic [WSEL_W-1:0] wr_wsel_i,
    input  logic [31:0]       wr_word_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_line_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= 1'b0;
        end else if (we_word_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tags and line data carry no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (we_line_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end else if (we_word_i) begin
            line_q[wr_idx_i][{wr_wsel_i, 5'b0} +: 32] <= wr_word_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign dirty_o = dirty_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional hit/miss counters when DCACHE_2WAY_STATS_EN is defined.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o
`ifdef DCACHE_2WAY_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int WSEL_W = OFF_W - 2;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic              req, hit, unused_addr;

    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign req_wsel    = p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^p1_addr_i[1:0];
    assign req         = p1_MemRead_i | p1_MemWrite_i;

    logic [1:0]              w_valid, w_dirty, hit_w, we_line, we_word;
    logic [1:0][TAG_W-1:0]   w_tag;
    logic [1:0][LINE_W-1:0]  w_line;

    state_t            state_q, state_d;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [SETS-1:0]   lru_q;
    logic              vic_way, vic_way_q, vic_dirty_q;
    logic [TAG_W-1:0]  vic_tag_q, miss_tag_q;
    logic [IDX_W-1:0]  miss_idx_q, wr_idx;
    logic [LINE_W-1:0] vic_line_q;
    logic              miss_start, refill_we, idle_hit;

    // Refill writes target the latched miss set so a dropped request cannot redirect it.
    assign wr_idx = refill_we ? miss_idx_q : req_idx;

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign hit_w[w]   = w_valid[w] & (w_tag[w] == req_tag);
        assign we_line[w] = refill_we & (vic_way_q == 1'(w));
        assign we_word[w] = hit_w[w] & p1_MemWrite_i & ((state_q == S_IDLE) | (state_q == S_DONE));

        dcache_way_array #(
            .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .WSEL_W(WSEL_W)
        ) u_way (
            .clk_i(clk_i), .rst_i(rst_i), .rd_idx_i(req_idx),
            .valid_o(w_valid[w]), .dirty_o(w_dirty[w]), .tag_o(w_tag[w]), .line_o(w_line[w]),
            .wr_idx_i(wr_idx), .we_line_i(we_line[w]), .wr_tag_i(miss_tag_q), .wr_line_i(mem_data_i),
            .we_word_i(we_word[w]), .wr_wsel_i(req_wsel), .wr_word_i(p1_data_i)
        );
    end

    assign hit        = |hit_w;
    assign idle_hit   = (state_q == S_IDLE) & req & hit;
    assign p1_stall_o = req & ~hit;
    assign p1_data_o  = hit ? word_sel(LINE_MAX_W'(w_line[hit_w[1]]), 5'(req_wsel)) : 32'd0;
    assign vic_way    = ~w_valid[0] ? 1'b0 : ~w_valid[1] ? 1'b1 : lru_q[req_idx];

    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        miss_start = 1'b0;
        refill_we  = 1'b0;
        case (state_q)
            S_IDLE: if (req && !hit) begin
                miss_start = 1'b1;
                state_d    = S_MISS;
            end
            S_MISS: begin
                mem_en_d = 1'b1;
                mem_wr_d = vic_dirty_q;
                state_d  = vic_dirty_q ? S_WB : S_REFILL;
            end
            S_WB: if (mem_ack_i) begin
                mem_wr_d = 1'b0;
                state_d  = S_REFILL;
            end
            S_REFILL: if (mem_ack_i) begin
                mem_en_d  = 1'b0;
                refill_we = 1'b1;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            lru_q       <= '0;
            vic_way_q   <= 1'b0;
            vic_dirty_q <= 1'b0;
            vic_tag_q   <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            mem_wr_q <= mem_wr_d;
            if (idle_hit) lru_q[req_idx] <= ~hit_w[1];
            if (miss_start) begin
                vic_way_q   <= vic_way;
                vic_dirty_q <= w_valid[vic_way] & w_dirty[vic_way];
                vic_tag_q   <= w_tag[vic_way];
                miss_tag_q  <= req_tag;
                miss_idx_q  <= req_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (miss_start) vic_line_q <= w_line[vic_way];
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = {(mem_wr_q ? vic_tag_q : miss_tag_q), miss_idx_q, {OFF_W{1'b0}}};
    assign mem_data_o   = vic_line_q;

    assert property (@(posedge clk_i) disable iff (!rst_i) !(hit_w[0] && hit_w[1]));

`ifdef DCACHE_2WAY_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit && hit_cnt_q != '1)    hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_start && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Parametrised two-way set-associative, write-back, write-allocate data cache.
- Sits between the pipelined CPU's MEM stage and the 256-bit-line data memory model.
- Successor to the direct-mapped dcache: set count and line width are parametrised, and each set has per-set LRU replacement.
- Keeps the same CPU and memory handshakes, so it drops into the existing CPU top unchanged.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, line width in bits; power of two, ≥64.
- SETS, 32, number of sets; power of two, ≥2.
- Derived:
  - OFF_W = log2(LINE_W/8).
  - IDX_W = log2(SETS).
  - TAG_W = ADDR_W − IDX_W − OFF_W.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  memory completion strobe for the current request.
- mem_data_o  out  LINE_W  victim line for write-back.
- mem_addr_o  out  ADDR_W  line-aligned memory address; low OFF_W bits are 0.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- p1_data_i  in  32  CPU store data.
- p1_addr_i  in  ADDR_W  CPU byte address; bits [1:0] ignored.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  CPU must hold its request while this is high.

Behaviour:
- Storage: per set, two ways, each holding valid, dirty, tag[TAG_W] and line[LINE_W]; plus one LRU bit per set (value = way to evict next). All held in flops.
- Reset (rst_i low, async):
  - All valid, dirty and LRU bits → 0; state → IDLE.
  - mem_enable_o, mem_write_o → 0.
  - Line data is not reset.
- Request and hit detection:
  - req = MemRead | MemWrite. If both are asserted, the request is treated as a store.
  - hit_w = valid_w & (tag_w == addr tag). Hit = hit_w0 | hit_w1. Both ways hitting is illegal and flagged by an assertion.
  - p1_stall_o = req & ~hit (combinational) in every state.
- Read hit, zero-latency:
  - p1_data_o = word at addr[OFF_W−1:2] of the hitting line, same cycle.
  - p1_data_o = 0 when there is no hit.
- Write hit: at the clock edge, write the 32-bit word into the hitting line and set its dirty bit.
- LRU update: on any hit at a clock edge while in IDLE, LRU[set] ← ~hitting way.
- FSM:
  - IDLE: on req & ~hit, latch the victim way and its tag, then go to MISS. Victim = way0 if invalid, else way1 if invalid, else LRU[set].
  - MISS:
    - Victim valid & dirty: mem_enable=1, mem_write=1, mem_addr = {victim tag, idx, 0}, mem_data_o = victim line; go to WRITEBACK.
    - Otherwise: mem_enable=1, mem_write=0, mem_addr = {req tag, idx, 0}; go to REFILL.
  - WRITEBACK: hold outputs until mem_ack_i. On ack: mem_write=0, address switches to the refill address, mem_enable stays 1; go to REFILL.
  - REFILL: on mem_ack_i, mem_enable=0. The victim way is written with line = mem_data_i, tag = req tag, valid=1, dirty=0. Go to REFILL_DONE.
  - REFILL_DONE: one cycle, then IDLE. The request now hits; a store completes as a write hit in that IDLE cycle.
- Output registers: mem_enable_o and mem_write_o are registered; mem_addr_o and mem_data_o are driven from the latched victim state.
- CPU contract: address and data are stable while p1_stall_o=1.
- Ignored inputs: mem_ack_i in IDLE, MISS and REFILL_DONE. A request drop mid-miss does not abort the line transfer.
- Reset mid-miss: returns to IDLE immediately, all lines invalid, memory request withdrawn.

Optional Feature:
- Macro DCACHE_2WAY_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments on every IDLE cycle with req & hit at the clock edge.
  - miss_cnt_o increments on each IDLE→MISS transition.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg:
  - FSM state enum (IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE).
  - Derived-width functions for OFF_W, IDX_W, TAG_W.
  - Line/word select helper.
- Sub-module dcache_way_array, instantiated twice:
  - SETS×(valid, dirty, tag, line) storage.
  - Combinational read port.
  - One synchronous write port, supporting a full-line write or a single-word write with dirty set.
  - Async reset of the valid/dirty bits.

Test Plan:
- Cold read 0x0000_0040 → stall asserted; refill request at addr 0x40; after ack, p1_data_o = mem word; stall drops; way0 valid.
- Fill way0 with 0x0040, then read 0x0440 (same set 2, different tag) → way1 filled with no write-back; both addresses then hit with no stall.
- Store 0xDEADBEEF to 0x0040, read 0x0440, then read 0x0840 → victim is way0 (LRU), write-back to 0x40 with the line containing 0xDEADBEEF, then refill of 0x840.
- Store miss to 0x0100 on a clean set → refill, then the word is written; a later read returns the stored value and the line's dirty bit is 1.
- Assert rst_i low during WRITEBACK → mem_enable_o=0 immediately; after release, a read of the same address misses.
- DCACHE_2WAY_STATS_EN build: 3 misses + 5 hits → miss_cnt_o=3, hit_cnt_o=5.
